// File: rtl/seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// seven_segment_scanner
//
// Time-multiplexed driver for a 4-digit, common-anode seven-segment display.
// A free-running prescaler sets the slot length (2^SCAN_BITS clocks per digit)
// and a 2-bit index picks the digit currently being driven. Host data goes
// into a shadow register on every update strobe. It moves into the displayed
// register only at the frame boundary (index 3 -> 0), so a frame never mixes
// old and new data. Every output is registered, which gives a 1-cycle latency
// relative to the prescaler, index and displayed state.
//
// At the start of each slot, all anodes are held off for GUARD_CYCLES clocks.
// This gives the cathodes time to settle before the next digit lights, so the
// previous digit does not ghost onto the new one.
//
// Parameters
//   SCAN_BITS         prescaler width; one digit slot = 2^SCAN_BITS clocks
//   GUARD_CYCLES      anode-off clocks at the start of each slot
//                     (0 < GUARD_CYCLES < 2^SCAN_BITS)
//
// Ports
//   clock             single clock, rising edge
//   reset             asynchronous, active-high
//   value[15:0]       four hex nibbles, value[3:0] is digit 0 (rightmost)
//   decimalPoints[3:0] bit i lights the decimal point of digit i
//   digitEnable[3:0]  bit i = 0 keeps digit i dark (sampled live)
//   blankLeadingZeros suppress leading zero digits 3..1 (sampled live)
//   update            capture strobe for value / decimalPoints into shadow
//   segments[6:0]     active-low cathodes, bit0 = a ... bit6 = g
//   dp                active-low decimal-point cathode
//   anodes[3:0]       active-low digit selects, bit i drives digit i
//
// Handshake: update is a plain level strobe. There is no ready signal: every
// clock with update = 1 overwrites the shadow, and the last strobe before a
// frame boundary is the one that gets displayed.
// -----------------------------------------------------------------------------
module seven_segment_scanner #(
  parameter int SCAN_BITS    = 16,
  parameter int GUARD_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  decimalPoints,
  input  logic [3:0]  digitEnable,
  input  logic        blankLeadingZeros,
  input  logic        update,
  output logic [6:0]  segments,
  output logic        dp,
  output logic [3:0]  anodes
);

  localparam logic [SCAN_BITS-1:0] GUARD_LIMIT = SCAN_BITS'(GUARD_CYCLES);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [SCAN_BITS-1:0] prescaler_q, prescaler_d;
  logic [1:0]           index_q,     index_d;

  logic [15:0]          shadow_value_q, shadow_value_d;
  logic [3:0]           shadow_dp_q,    shadow_dp_d;
  logic [15:0]          disp_value_q,   disp_value_d;
  logic [3:0]           disp_dp_q,      disp_dp_d;

  logic [3:0]           anodes_q,   anodes_d;
  logic [6:0]           segments_q, segments_d;
  logic                 dp_q,       dp_d;

  // ---------------------------------------------------------------------------
  // Hex to active-high gfedcba decoder
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] decode_hex(input logic [3:0] nibble);
    logic [6:0] pattern;
    case (nibble)
      4'h0:    pattern = 7'h3F;
      4'h1:    pattern = 7'h06;
      4'h2:    pattern = 7'h5B;
      4'h3:    pattern = 7'h4F;
      4'h4:    pattern = 7'h66;
      4'h5:    pattern = 7'h6D;
      4'h6:    pattern = 7'h7D;
      4'h7:    pattern = 7'h07;
      4'h8:    pattern = 7'h7F;
      4'h9:    pattern = 7'h6F;
      4'hA:    pattern = 7'h77;
      4'hB:    pattern = 7'h7C;
      4'hC:    pattern = 7'h39;
      4'hD:    pattern = 7'h5E;
      4'hE:    pattern = 7'h79;
      default: pattern = 7'h71;
    endcase
    return pattern;
  endfunction

  // ---------------------------------------------------------------------------
  // Timebase: prescaler, digit index, frame boundary
  // ---------------------------------------------------------------------------
  logic slot_wrap;       // prescaler is all-ones; the next clock starts a slot
  logic frame_boundary;  // last clock of digit 3; the next clock starts a frame

  always_comb begin
    slot_wrap      = &prescaler_q;
    frame_boundary = slot_wrap && (index_q == 2'd3);
    prescaler_d    = prescaler_q + 1'b1;
    index_d        = index_q;
    if (slot_wrap) begin
      index_d = index_q + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow / displayed data path
  // ---------------------------------------------------------------------------
  // The displayed register takes the shadow value as it stands before this
  // clock's strobe. If update arrives on the boundary clock itself, that data
  // lands in the shadow and is shown one frame later.
  always_comb begin
    shadow_value_d = shadow_value_q;
    shadow_dp_d    = shadow_dp_q;
    disp_value_d   = disp_value_q;
    disp_dp_d      = disp_dp_q;
    if (update) begin
      shadow_value_d = value;
      shadow_dp_d    = decimalPoints;
    end
    if (frame_boundary) begin
      disp_value_d = shadow_value_q;
      disp_dp_d    = shadow_dp_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit selection and darkness
  // ---------------------------------------------------------------------------
  logic [3:0] lz_blank;    // digit i sits in a run of leading zeros
  logic [3:0] dark_vec;    // digit i must stay unlit
  logic [3:0] cur_nibble;
  logic       cur_dark;
  logic       cur_dp_bit;
  logic       in_guard;

  always_comb begin
    // Leading-zero run, built from the top nibble downward. Digit 0 is never
    // part of the run, so a value of zero still shows a single "0".
    lz_blank[3] = (disp_value_q[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] && (disp_value_q[11:8] == 4'h0);
    lz_blank[1] = lz_blank[2] && (disp_value_q[7:4]  == 4'h0);
    lz_blank[0] = 1'b0;

    dark_vec = ~digitEnable | ({4{blankLeadingZeros}} & lz_blank);

    case (index_q)
      2'd0:    cur_nibble = disp_value_q[3:0];
      2'd1:    cur_nibble = disp_value_q[7:4];
      2'd2:    cur_nibble = disp_value_q[11:8];
      default: cur_nibble = disp_value_q[15:12];
    endcase

    cur_dark   = dark_vec[index_q];
    cur_dp_bit = disp_dp_q[index_q];
    in_guard   = (prescaler_q < GUARD_LIMIT);
  end

  // ---------------------------------------------------------------------------
  // Output pattern (registered next cycle)
  // ---------------------------------------------------------------------------
  always_comb begin
    anodes_d   = 4'b1111;
    segments_d = 7'h7F;
    dp_d       = 1'b1;
    if (!cur_dark) begin
      // Cathodes follow the current digit through the guard period as well.
      // Only the anode is held off, so the new pattern has settled by the
      // time the digit lights.
      segments_d = ~decode_hex(cur_nibble);
      dp_d       = ~cur_dp_bit;
      if (!in_guard) begin
        anodes_d = ~(4'b0001 << index_q);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler_q    <= '0;
      index_q        <= 2'd0;
      shadow_value_q <= 16'h0000;
      shadow_dp_q    <= 4'h0;
      disp_value_q   <= 16'h0000;
      disp_dp_q      <= 4'h0;
      anodes_q       <= 4'b1111;
      segments_q     <= 7'h7F;
      dp_q           <= 1'b1;
    end else begin
      prescaler_q    <= prescaler_d;
      index_q        <= index_d;
      shadow_value_q <= shadow_value_d;
      shadow_dp_q    <= shadow_dp_d;
      disp_value_q   <= disp_value_d;
      disp_dp_q      <= disp_dp_d;
      anodes_q       <= anodes_d;
      segments_q     <= segments_d;
      dp_q           <= dp_d;
    end
  end

  assign anodes   = anodes_q;
  assign segments = segments_q;
  assign dp       = dp_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// Bench for seven_segment_scanner with SCAN_BITS = 4, GUARD_CYCLES = 2
// (16-clock slots, 64-clock frames).
//
// st counts rising edges since reset release. After st edges, the outputs
// show the state the DUT held at st-1: prescaler = (st-1) % 16,
// index = ((st-1) / 16) % 4. Expected values are pushed onto exp_q when the
// stimulus is driven. They are popped and compared #1 after the edge at
// which the matching output appears.
//
// Expected-entry layout: {guard_only, anodes[3:0], segments[6:0], dp}.
// A guard_only entry compares anodes only.
// -----------------------------------------------------------------------------
module tb_seven_segment_scanner;

  localparam int SB = 4;
  localparam int GC = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clock;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  decimalPoints;
  logic [3:0]  digitEnable;
  logic        blankLeadingZeros;
  logic        update;
  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  anodes;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  seven_segment_scanner #(
    .SCAN_BITS   (SB),
    .GUARD_CYCLES(GC)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .value            (value),
    .decimalPoints    (decimalPoints),
    .digitEnable      (digitEnable),
    .blankLeadingZeros(blankLeadingZeros),
    .update           (update),
    .segments         (segments),
    .dp               (dp),
    .anodes           (anodes)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [12:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          st       = 0;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dps;
    logic [3:0]  en;
    logic        blz;
    logic [27:0] segs;  // {d3, d2, d1, d0}, active-low
    logic [3:0]  dpo;   // expected dp per digit slot
    logic [3:0]  lit;   // digit expected to light its anode
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
    st++;
  endtask

  task automatic goto_edge(input int target);
    if (target < st) begin
      checks++;
      failures++;
      $display("FAIL goto: at edge %0d, required edge %0d", st, target);
    end
    while (st < target) tick();
  endtask

  task automatic strobe(input logic [15:0] v, input logic [3:0] dps);
    value         = v;
    decimalPoints = dps;
    update        = 1'b1;
    tick();
    update        = 1'b0;
  endtask

  task automatic push_full(input logic [3:0] an, input logic [6:0] sg, input logic d);
    exp_q.push_back({1'b0, an, sg, d});
  endtask

  task automatic push_guard();
    exp_q.push_back({1'b1, 4'b1111, 8'h00});
  endtask

  task automatic check_next(input string name);
    logic [12:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: got an=%b seg=%h dp=%b, required entry missing", name, anodes, segments, dp);
      return;
    end
    e = exp_q.pop_front();
    if (e[12]) begin
      if (anodes !== e[11:8]) begin
        failures++;
        $display("FAIL %s: got an=%b, required an=%b", name, anodes, e[11:8]);
      end
    end else if ({anodes, segments, dp} !== e[11:0]) begin
      failures++;
      $display("FAIL %s: got an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
               name, anodes, segments, dp, e[11:8], e[7:1], e[0]);
    end
  endtask

  task automatic check_at(input int target, input string name);
    goto_edge(target);
    check_next(name);
  endtask

  // Target edge for DUT state (frame start fs, digit d, prescaler p).
  function automatic int edge_of(input int fs, input int d, input int p);
    return fs + 16 * d + p + 1;
  endfunction

  function automatic int next_frame();
    return (st / 64 + 1) * 64;
  endfunction

  // Release reset away from the clock edge; then digit 0 lights on edge 3.
  task automatic release_and_check(input string tag);
    reset = 1'b0;
    st    = 0;
    push_guard();
    push_guard();
    push_full(4'b1110, 7'h40, 1'b1);
    tick(); check_next({tag, "_edge1"});
    tick(); check_next({tag, "_edge2"});
    tick(); check_next({tag, "_edge3"});
  endtask

  // ---------------------------------------------------------------------------
  // Test
  // ---------------------------------------------------------------------------
  initial begin
    int fs;
    logic [3:0] an;

    vecs[0] = '{16'h12AF, 4'b0000, 4'b1111, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111, 4'b1111};
    vecs[1] = '{16'h0005, 4'b0000, 4'b1111, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1111, 4'b0001};
    vecs[2] = '{16'h0000, 4'b0000, 4'b1111, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111, 4'b0001};
    vecs[3] = '{16'h0040, 4'b0000, 4'b1111, 1'b1, {7'h7F, 7'h7F, 7'h19, 7'h40}, 4'b1111, 4'b0011};
    vecs[4] = '{16'h0300, 4'b0000, 4'b1111, 1'b1, {7'h7F, 7'h30, 7'h40, 7'h40}, 4'b1111, 4'b0111};
    vecs[5] = '{16'h12AF, 4'b0100, 4'b1111, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011, 4'b1111};
    vecs[6] = '{16'h12AF, 4'b0100, 4'b1011, 1'b0, {7'h79, 7'h7F, 7'h08, 7'h0E}, 4'b1111, 4'b1011};
    vecs[7] = '{16'h89BC, 4'b1001, 4'b1111, 1'b0, {7'h00, 7'h10, 7'h03, 7'h46}, 4'b0110, 4'b1111};
    vecs[8] = '{16'h0050, 4'b0000, 4'b1110, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h7F}, 4'b1111, 4'b0010};
    vecs[9] = '{16'hDE67, 4'b0000, 4'b1111, 1'b0, {7'h21, 7'h06, 7'h02, 7'h78}, 4'b1111, 4'b1111};

    reset             = 1'b1;
    value             = 16'h0000;
    decimalPoints     = 4'h0;
    digitEnable       = 4'hF;
    blankLeadingZeros = 1'b0;
    update            = 1'b0;

    // Power-on reset: outputs dark while reset is held.
    repeat (3) @(posedge clock);
    #1;
    push_full(4'b1111, 7'h7F, 1'b1);
    check_next("por_hold");
    release_and_check("por");

    // Table-driven vectors: load in frame fs, check every slot of fs+64.
    for (int k = 0; k < NV; k++) begin
      fs = next_frame();
      goto_edge(fs + 10);
      digitEnable       = vecs[k].en;
      blankLeadingZeros = vecs[k].blz;
      for (int d = 0; d < 4; d++) begin
        an = vecs[k].lit[d] ? ~(4'b0001 << d) : 4'b1111;
        push_guard();
        push_full(an, vecs[k].segs[d*7 +: 7], vecs[k].dpo[d]);
        push_full(an, vecs[k].segs[d*7 +: 7], vecs[k].dpo[d]);
      end
      strobe(vecs[k].value, vecs[k].dps);
      for (int d = 0; d < 4; d++) begin
        check_at(edge_of(fs + 64, d, 1),  $sformatf("vec%0d_d%0d_guard", k, d));
        check_at(edge_of(fs + 64, d, 2),  $sformatf("vec%0d_d%0d_first", k, d));
        check_at(edge_of(fs + 64, d, 15), $sformatf("vec%0d_d%0d_last", k, d));
      end
    end

    // Tear-free: strobe 1111 during digit 1 of a DE67 frame.
    fs = next_frame();
    goto_edge(fs + 16 + 5);
    push_full(4'b1011, 7'h06, 1'b1);
    push_full(4'b0111, 7'h21, 1'b1);
    for (int d = 0; d < 4; d++) push_full(~(4'b0001 << d), 7'h79, 1'b1);
    strobe(16'h1111, 4'h0);
    check_at(edge_of(fs, 2, 8), "tear_old_d2");
    check_at(edge_of(fs, 3, 8), "tear_old_d3");
    for (int d = 0; d < 4; d++)
      check_at(edge_of(fs + 64, d, 8), $sformatf("tear_new_d%0d", d));

    // Last strobe wins; a strobe on the boundary clock shows one frame later.
    fs = next_frame();
    push_full(4'b1110, 7'h79, 1'b1);  // frame fs+64: 4321, digit 0 = 1
    push_full(4'b0111, 7'h19, 1'b1);  // frame fs+64: digit 3 = 4
    push_full(4'b1110, 7'h00, 1'b1);  // frame fs+128: 5678, digit 0 = 8
    push_full(4'b0111, 7'h12, 1'b1);  // frame fs+128: digit 3 = 5
    goto_edge(fs + 10);
    strobe(16'h0009, 4'h0);
    goto_edge(fs + 30);
    strobe(16'h4321, 4'h0);
    goto_edge(fs + 63);
    strobe(16'h5678, 4'h0);
    check_at(edge_of(fs + 64, 0, 8),  "bnd_prev_d0");
    check_at(edge_of(fs + 64, 3, 8),  "bnd_prev_d3");
    check_at(edge_of(fs + 128, 0, 8), "bnd_new_d0");
    check_at(edge_of(fs + 128, 3, 8), "bnd_new_d3");

    // Mid-slot reset with pending shadow data that must be discarded.
    fs = next_frame();
    goto_edge(fs + 10);
    strobe(16'h1234, 4'hF);
    goto_edge(fs + 24);
    #3;
    reset = 1'b1;
    #1;
    push_full(4'b1111, 7'h7F, 1'b1);
    check_next("rst_async");
    tick();
    push_full(4'b1111, 7'h7F, 1'b1);
    check_next("rst_held");
    tick();
    release_and_check("rst");
    push_full(4'b1110, 7'h40, 1'b1);
    push_full(4'b1101, 7'h40, 1'b1);
    push_full(4'b0111, 7'h40, 1'b1);
    check_at(edge_of(64, 0, 8), "rst_discard_d0");
    check_at(edge_of(64, 1, 8), "rst_discard_d1");
    check_at(edge_of(64, 3, 8), "rst_discard_d3");

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
